// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter FSM state encoding, the requester identifiers used both
// by the round-robin chooser and the top level, and the legal latency range.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IF = 1'b0;
    localparam req_id_t REQ_DM = 1'b1;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin chooser: picks the winner among two eligible requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only samples the winner when a grant is taken.
//
// Ports:
//   elig_if, elig_dm : requester is eligible for a grant this cycle
//   last_gnt         : requester that received the previous grant
//   winner           : chosen requester (meaningful only if any eligible)
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic    elig_if,
    input  logic    elig_dm,
    input  req_id_t last_gnt,
    output req_id_t winner
);

    always_comb begin
        winner = REQ_IF;
        if (elig_if && elig_dm) begin
            // Conflict: hand the port to whoever did not have it last.
            winner = (last_gnt == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (elig_dm) begin
            winner = REQ_DM;
        end else begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Latency: gnt one cycle after req is seen in IDLE; valid MEM_LAT cycles after gnt.
// Backpressure: one access in flight; requesters hold req/addr/data until valid.
//
// Ports:
//   clk1, rst                          : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_valid/if_rdata            : fetch port
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_valid/dm_rdata : load/store port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata           : shared memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk1,
    input  logic              rst,

    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < LAT_MIN || MEM_LAT > LAT_MAX) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    arb_state_t state;
    logic [3:0] cnt;
    req_id_t    last_gnt;
    req_id_t    owner;
    req_id_t    winner;
    logic       elig_if;
    logic       elig_dm;

    // A requester that is completing this cycle is still holding req; it must
    // not be re-granted off that stale request.
    assign elig_if = if_req && !if_valid;
    assign elig_dm = dm_req && !dm_valid;

    arb_rr2 u_arb (
        .elig_if  (elig_if),
        .elig_dm  (elig_dm),
        .last_gnt (last_gnt),
        .winner   (winner)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_gnt  <= REQ_IF;
            owner     <= REQ_IF;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // Grant and completion strobes are single-cycle pulses.
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            mem_en   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (elig_if || elig_dm) begin
                        state    <= WAIT;
                        cnt      <= LAT4;
                        owner    <= winner;
                        last_gnt <= winner;
                        mem_en   <= 1'b1;
                        if (winner == REQ_DM) begin
                            dm_gnt    <= 1'b1;
                            mem_addr  <= dm_addr;
                            mem_we    <= dm_we;
                            mem_wdata <= dm_wdata;
                        end else begin
                            if_gnt    <= 1'b1;
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end

                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        // mem_we is still the owner's latched direction here.
                        if (owner == REQ_DM) begin
                            dm_valid <= 1'b1;
                            dm_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with MEM_LAT=2 and a latency-exact memory model.
// Latency: n/a (testbench).
// Backpressure: requesters hold req/addr/data until their valid pulse.
module tb_mem_port_arbiter;

    localparam int DW = 32;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we;
    logic [DW-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic          if_gnt, if_valid, dm_gnt, dm_valid;
    logic          mem_en, mem_we;
    logic [DW-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    always #5 clk1 = ~clk1;

    mem_port_arbiter #(.DATA_W(DW), .MEM_LAT(2)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic          id;
        logic [DW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            gap;   // expected cycles since previous grant, 0 = unchecked
    } gnt_exp_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] rdata;
    } cpl_exp_t;

    gnt_exp_t gq[$];
    cpl_exp_t cq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_gnt_cyc = 0;

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memval(input logic [DW-1:0] a);
        if (a == 32'h0000_0010) return 32'h8C22_0004;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Read data is only correct during the cycle after mem_en, i.e. the
    // cycle whose closing edge is gnt+MEM_LAT-1; otherwise it is poison.
    always @(posedge clk1) begin
        mem_rdata <= 32'hBAD0_BAD0;
        if (mem_en && !mem_we) mem_rdata <= memval(mem_addr);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_msg(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_if_gnt"},    {31'd0, if_gnt},    0);
        chk({tag, "_if_valid"},  {31'd0, if_valid},  0);
        chk({tag, "_if_rdata"},  if_rdata,           0);
        chk({tag, "_dm_gnt"},    {31'd0, dm_gnt},    0);
        chk({tag, "_dm_valid"},  {31'd0, dm_valid},  0);
        chk({tag, "_dm_rdata"},  dm_rdata,           0);
        chk({tag, "_mem_en"},    {31'd0, mem_en},    0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    0);
        chk({tag, "_mem_addr"},  mem_addr,           0);
        chk({tag, "_mem_wdata"}, mem_wdata,          0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or completion.
    always @(negedge clk1) begin
        if (if_gnt === 1'b1 || dm_gnt === 1'b1) begin
            gnt_exp_t g;
            chk("gnt_exclusive", {31'd0, if_gnt & dm_gnt}, 0);
            if (gq.size() == 0) begin
                fail_msg("gnt_unexpected");
            end else begin
                g = gq.pop_front();
                chk("gnt_id",     {31'd0, dm_gnt}, {31'd0, g.id});
                chk("gnt_mem_en", {31'd0, mem_en}, 1);
                chk("gnt_addr",   mem_addr,        g.addr);
                chk("gnt_we",     {31'd0, mem_we}, {31'd0, g.we});
                chk("gnt_wdata",  mem_wdata,       g.wdata);
                if (g.gap != 0) chk("gnt_period", cyc - last_gnt_cyc, g.gap);
            end
            last_gnt_cyc = cyc;
        end
        if (if_valid === 1'b1 || dm_valid === 1'b1) begin
            cpl_exp_t c;
            chk("valid_exclusive", {31'd0, if_valid & dm_valid}, 0);
            if (cq.size() == 0) begin
                fail_msg("valid_unexpected");
            end else begin
                c = cq.pop_front();
                chk("valid_id",      {31'd0, dm_valid}, {31'd0, c.id});
                chk("valid_latency", cyc - last_gnt_cyc, 2);
                chk("rdata", c.id ? dm_rdata : if_rdata, c.rdata);
            end
        end
    end

    // Requester processes: called just after a rising edge; hold req through
    // each access, move to the next address in the valid cycle.
    task automatic run_if(input int n, input logic [DW-1:0] a0);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if_addr = a0 + DW'(8 * i);
            if_req  = 1'b1;
            do begin
                @(posedge clk1); #1; t++;
            end while (!if_valid && t < 40);
            if (!if_valid) fail_msg("if_timeout");
        end
        if_req = 1'b0;
    endtask

    task automatic run_dm(input int n, input logic [DW-1:0] a0, input logic we, input logic [DW-1:0] wd);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            dm_addr  = a0 + DW'(8 * i);
            dm_we    = we;
            dm_wdata = wd;
            dm_req   = 1'b1;
            do begin
                @(posedge clk1); #1; t++;
            end while (!dm_valid && t < 40);
            if (!dm_valid) fail_msg("dm_timeout");
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic exp_gnt(input logic id, input logic [DW-1:0] a, input logic we,
                           input logic [DW-1:0] wd, input int gap);
        gnt_exp_t g;
        g.id = id; g.addr = a; g.we = we; g.wdata = wd; g.gap = gap;
        gq.push_back(g);
    endtask

    task automatic exp_cpl(input logic id, input logic [DW-1:0] d);
        cpl_exp_t c;
        c.id = id; c.rdata = d;
        cq.push_back(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    initial begin
        int t;
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        idle(2);
        @(negedge clk1);
        check_zero("reset");
        @(posedge clk1); #1;
        rst = 1'b0;

        // Conflict straight after reset: DM first, IF three cycles later.
        exp_gnt(1'b1, 32'h40, 1'b0, 32'h0, 0);
        exp_cpl(1'b1, memval(32'h40));
        exp_gnt(1'b0, 32'h100, 1'b0, 32'h0, 3);
        exp_cpl(1'b0, memval(32'h100));
        fork
            run_dm(1, 32'h40, 1'b0, 32'h0);
            run_if(1, 32'h100);
        join
        idle(2);

        // Single fetch.
        exp_gnt(1'b0, 32'h10, 1'b0, 32'h0, 0);
        exp_cpl(1'b0, 32'h8C22_0004);
        run_if(1, 32'h10);
        idle(2);

        // Both held for six grants: DM,IF,DM,IF,DM,IF every 3 cycles.
        for (int i = 0; i < 3; i++) begin
            exp_gnt(1'b1, 32'h200 + 32'(8 * i), 1'b0, 32'h0, (i == 0) ? 0 : 3);
            exp_cpl(1'b1, memval(32'h200 + 32'(8 * i)));
            exp_gnt(1'b0, 32'h300 + 32'(8 * i), 1'b0, 32'h0, 3);
            exp_cpl(1'b0, memval(32'h300 + 32'(8 * i)));
        end
        fork
            run_dm(3, 32'h200, 1'b0, 32'h0);
            run_if(3, 32'h300);
        join
        idle(2);

        // Store: write data on the bus, completion returns zero.
        exp_gnt(1'b1, 32'h44, 1'b1, 32'hDEAD_BEEF, 0);
        exp_cpl(1'b1, 32'h0);
        run_dm(1, 32'h44, 1'b1, 32'hDEAD_BEEF);
        idle(2);

        // Reset in the middle of a fetch: no completion, all outputs cleared.
        exp_gnt(1'b0, 32'h20, 1'b0, 32'h0, 0);
        if_addr = 32'h20;
        if_req  = 1'b1;
        t = 0;
        do begin
            @(posedge clk1); #1; t++;
        end while (!if_gnt && t < 20);
        if (!if_gnt) fail_msg("rst_fetch_gnt_timeout");
        rst    = 1'b1;
        if_req = 1'b0;
        @(posedge clk1); #1;
        check_zero("midwait_rst");
        rst = 1'b0;
        idle(6);

        // Traffic resumes normally after the aborted fetch.
        exp_gnt(1'b1, 32'h60, 1'b0, 32'h0, 0);
        exp_cpl(1'b1, memval(32'h60));
        run_dm(1, 32'h60, 1'b0, 32'h0);
        idle(3);

        t = 0;
        while ((gq.size() != 0 || cq.size() != 0) && t < 50) begin
            @(posedge clk1); t++;
        end
        chk("gnt_queue_drained", gq.size(), 0);
        chk("cpl_queue_drained", cq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
